mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  Memory->Writeback pipeline register plus writeback datapath, directly downstream of Data_Memory.
//  Latches M-stage results (ALUResultM, ReadData, PCPlus4M, control) on clk.
//  In W it extracts and extends load data by funct3 and selects ResultW for the register file.
//  Also keeps a retired-instruction counter.
// PARAMETERS
//  XLEN      32  datapath width
//  CNT_W     32  width of retired-instruction counter
// PORTS
//  clk          in   1      rising-edge clock (only clock)
//  rst          in   1      synchronous reset, active-high
//  StallW       in   1      hold all W registers
//  FlushW       in   1      load a bubble into W
//  ValidM       in   1      M-stage slot holds a real instruction
//  RegWriteM    in   1      instruction writes rd
//  ResultSrcM   in   2      00 ALU, 01 load, 10 PC+4, 11 zero
//  Funct3M      in   3      load size/sign
//  RdM          in   5      destination register
//  ALUResultM   in   XLEN   ALU result / memory address
//  ReadDataM    in   XLEN   word from Data_Memory ReadData
//  PCPlus4M     in   XLEN   PC+4 of instruction
//  RegWriteW    out  1      register-file write enable
//  RdW          out  5      register-file write address
//  ResultW      out  XLEN   register-file write data (also forwarded to E)
//  ValidW       out  1      W slot holds a real instruction
//  InstrRetW    out  CNT_W  retired-instruction count
//  MisalignW    out  1      misaligned load in W (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all W registers and InstrRetW <- 0. RegWriteW=0, ResultW=0, ValidW=0.
//  - Priority each posedge: rst > FlushW > StallW > normal load.
//  - Normal: W regs <- M inputs. Latency is 1 cycle, M inputs to W outputs.
//  - FlushW: ValidW<=0, RegWriteW<=0, RdW<=0, data regs<=0; counter unchanged.
//  - StallW (no flush): every W register and InstrRetW hold.
//  - RegWriteW = RegWriteW_q & ValidW; RdW==0 forces RegWriteW=0.
//  - ResultW is combinational from W regs. ResultSrc 00->ALUResultW, 01->LoadExtW, 10->PCPlus4W, 11->0.
//  - Lane select: off = ALUResultW[1:0].
//  - Load extraction:
//    - LB 000: sext byte[off].
//    - LH 001: sext half[off[1]].
//    - LW 010: word.
//    - LBU 100: zext byte[off].
//    - LHU 101: zext half[off[1]].
//    - Other funct3: word unchanged.
//  - InstrRetW: +1 on each posedge that loads W with ValidM=1 (no rst/flush/stall). Wraps at 2^CNT_W.
//  - A stall during a valid entry does not recount it.
//  - Reset mid-stall or mid-flush: reset wins, and everything is zero next cycle.
// CONFIGURATION
//  Macro MISALIGN_TRAP_EN.
//  - Defined: a ResultSrc=01 load with LH/LHU and off[0]=1, or LW and off!=0, sets MisalignW=1 for that W entry.
//    RegWriteW is forced 0 and InstrRetW does not increment for it.
//    The check is done at M and latched with the entry.
//  - Undefined: MisalignW tied 0. Misaligned loads write extracted data per the lane rules; no suppression.
// STRUCTURE
//  - Shared package wb_pkg:
//    - ResultSrc encodings RES_ALU/RES_LOAD/RES_PC4/RES_ZERO.
//    - Load funct3 constants F3_LB/LH/LW/LBU/LHU.
//    - XLEN default.
//  - Sub-module load_extend (combinational): word, off, funct3 in; extended XLEN value out.
//  - Top holds the registers, result mux and counter.
// TESTING
//  1. rst=1 two cycles -> RegWriteW=0, ResultW=0, ValidW=0, InstrRetW=0.
//  2. Load Funct3M=000, ALUResultM=5 (off 01), ReadDataM=0x1234_80FF:
//     - next cycle ResultW=0xFFFF_FF80.
//     - same with LBU -> 0x0000_0080.
//  3. ALU op RdM=3, ALUResultM=0xA5 with StallW=1 for 3 cycles:
//     - W outputs and InstrRetW hold the previous entry.
//     - after release, ResultW=0xA5 and InstrRetW increments by 1.
//  4. FlushW and StallW together with a valid ALU op -> next cycle ValidW=0, RegWriteW=0, InstrRetW unchanged.
//  5. ResultSrcM=10, PCPlus4M=0x104, RdM=1 -> ResultW=0x104. Same with RdM=0 -> RegWriteW=0.
//  6. MISALIGN_TRAP_EN, LW at ALUResultM=6:
//     - defined: MisalignW=1, RegWriteW=0, count unchanged.
//     - undefined: MisalignW=0, write occurs.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: result-source select, load funct3 codes, datapath width.
// Also holds the misaligned-load predicate evaluated in M.
package wb_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_ZERO = 2'b11
  } res_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  function automatic logic is_misaligned(input logic [1:0] src, input logic [2:0] f3,
                                         input logic [1:0] off);
    logic half_bad;
    logic word_bad;
    half_bad = ((f3 == F3_LH) || (f3 == F3_LHU)) && off[0];
    word_bad = (f3 == F3_LW) && (off != 2'b00);
    return (src == RES_LOAD) && (half_bad || word_bad);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data extraction: picks the byte/half lane addressed by off and extends it per funct3.
// Unknown funct3 codes pass the word through untouched.
module load_extend
  import wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{off, 3'b000} +: 8];
    half_sel = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LBU:  ext = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  ext = {{(XLEN-16){1'b0}}, half_sel};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// M->W pipeline register, writeback result mux and retired-instruction counter (1-cycle latency).
// Optional misaligned-load trapping is enabled by defining MISALIGN_TRAP_EN.
module mem_wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StallW,
  input  logic             FlushW,
  input  logic             ValidM,
  input  logic             RegWriteM,
  input  logic [1:0]       ResultSrcM,
  input  logic [2:0]       Funct3M,
  input  logic [4:0]       RdM,
  input  logic [XLEN-1:0]  ALUResultM,
  input  logic [XLEN-1:0]  ReadDataM,
  input  logic [XLEN-1:0]  PCPlus4M,
  output logic             RegWriteW,
  output logic [4:0]       RdW,
  output logic [XLEN-1:0]  ResultW,
  output logic             ValidW,
  output logic [CNT_W-1:0] InstrRetW,
  output logic             MisalignW
);

  logic            valid_q;
  logic            regwrite_q;
  logic [4:0]      rd_q;
  logic [1:0]      src_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] pc4_q;
  logic            mis_q;
  logic [CNT_W-1:0] cnt_q;
  logic            misalign_m;
  logic [XLEN-1:0] load_ext;

  // Misalignment is judged on M inputs so the flag travels with its entry.
`ifdef MISALIGN_TRAP_EN
  assign misalign_m = is_misaligned(ResultSrcM, Funct3M, ALUResultM[1:0]);
`else
  assign misalign_m = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      src_q      <= RES_ALU;
      f3_q       <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      pc4_q      <= '0;
      mis_q      <= 1'b0;
      cnt_q      <= '0;
    end else if (FlushW) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      src_q      <= RES_ALU;
      f3_q       <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      pc4_q      <= '0;
      mis_q      <= 1'b0;
    end else if (!StallW) begin
      valid_q    <= ValidM;
      regwrite_q <= RegWriteM;
      rd_q       <= RdM;
      src_q      <= ResultSrcM;
      f3_q       <= Funct3M;
      alu_q      <= ALUResultM;
      rdata_q    <= ReadDataM;
      pc4_q      <= PCPlus4M;
      mis_q      <= misalign_m;
      if (ValidM && !misalign_m) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .word   (rdata_q),
    .off    (alu_q[1:0]),
    .funct3 (f3_q),
    .ext    (load_ext)
  );

  always_comb begin
    case (res_src_e'(src_q))
      RES_ALU:  ResultW = alu_q;
      RES_LOAD: ResultW = load_ext;
      RES_PC4:  ResultW = pc4_q;
      default:  ResultW = '0;
    endcase
  end

  assign RegWriteW = regwrite_q & valid_q & (rd_q != 5'd0) & ~mis_q;
  assign RdW       = rd_q;
  assign ValidW    = valid_q;
  assign InstrRetW = cnt_q;
  assign MisalignW = mis_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized and directed bench for mem_wb_stage against an architectural writeback model.
// Honours MISALIGN_TRAP_EN the same way the design does.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, StallW, FlushW, ValidM, RegWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, ReadDataM, PCPlus4M;
  logic        RegWriteW, ValidW, MisalignW;
  logic [4:0]  RdW;
  logic [31:0] ResultW, InstrRetW;

  int vectors = 0;
  int errors  = 0;

  // Model of what the W outputs should show.
  logic        m_rw, m_valid, m_mis;
  logic [4:0]  m_rd;
  logic [31:0] m_res, m_cnt;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RdM(RdM),
    .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .ValidW(ValidW),
    .InstrRetW(InstrRetW), .MisalignW(MisalignW)
  );

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'h80)   ? b - 32'h100   : b;
      3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic ref_mis(input logic [1:0] src, input logic [2:0] f3, input int off);
`ifdef MISALIGN_TRAP_EN
    if (src != 2'd1) return 1'b0;
    if ((f3 == 3'd1 || f3 == 3'd5) && (off % 2 != 0)) return 1'b1;
    if (f3 == 3'd2 && off != 0) return 1'b1;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_idle();
    rst = 0; StallW = 0; FlushW = 0; ValidM = 0; RegWriteM = 0; ResultSrcM = 0;
    Funct3M = 0; RdM = 0; ALUResultM = 0; ReadDataM = 0; PCPlus4M = 0;
  endtask

  task automatic set_op(input logic [1:0] src, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] pc4);
    ValidM = 1; RegWriteM = 1; ResultSrcM = src; Funct3M = f3; RdM = rd;
    ALUResultM = alu; ReadDataM = rdata; PCPlus4M = pc4;
  endtask

  // One clock: DUT samples the held inputs, model applies the same rules, outputs are read at negedge.
  task automatic cycle();
    int off;
    logic mis;
    @(posedge clk);
    off = int'(ALUResultM % 4);
    mis = ref_mis(ResultSrcM, Funct3M, off);
    if (rst) begin
      m_rw = 0; m_valid = 0; m_mis = 0; m_rd = 0; m_res = 0; m_cnt = 0;
    end else if (FlushW) begin
      m_rw = 0; m_valid = 0; m_mis = 0; m_rd = 0; m_res = 0;
    end else if (!StallW) begin
      m_valid = ValidM;
      m_rd    = RdM;
      m_mis   = mis;
      m_rw    = RegWriteM && ValidM && (RdM != 0) && !mis;
      case (ResultSrcM)
        2'd0: m_res = ALUResultM;
        2'd1: m_res = ref_load(Funct3M, off, ReadDataM);
        2'd2: m_res = PCPlus4M;
        default: m_res = 0;
      endcase
      if (ValidM && !mis) m_cnt = m_cnt + 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1;
    cycle();
    cycle();
    vectors++; if (RegWriteW !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %0b want 0", RegWriteW); end
    vectors++; if (ResultW !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", ResultW); end
    vectors++; if (ValidW !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", ValidW); end
    vectors++; if (InstrRetW !== 32'h0) begin errors++; $display("FAIL reset_instret got %0d want 0", InstrRetW); end
    vectors++; if (MisalignW !== 1'b0) begin errors++; $display("FAIL reset_misalign got %0b want 0", MisalignW); end
    rst = 0;
  endtask

  task automatic test_load_extend();
    set_idle();
    set_op(2'b01, 3'b000, 5'd7, 32'd5, 32'h1234_80FF, 32'h0);
    cycle();
    vectors++; if (ResultW !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_off1 got %h want ffffff80", ResultW); end
    vectors++; if (RegWriteW !== 1'b1) begin errors++; $display("FAIL lb_regwrite got %0b want 1", RegWriteW); end
    Funct3M = 3'b100;
    cycle();
    vectors++; if (ResultW !== 32'h0000_0080) begin errors++; $display("FAIL lbu_off1 got %h want 00000080", ResultW); end
    for (int f = 0; f < 8; f++) begin
      for (int o = 0; o < 4; o++) begin
        Funct3M = 3'(f); ALUResultM = $urandom & 32'hFFFF_FFFC | 32'(o); ReadDataM = $urandom;
        cycle();
        vectors++; if (ResultW !== m_res) begin errors++; $display("FAIL load_f3_%0d_off_%0d got %h want %h", f, o, ResultW, m_res); end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] h_res, h_cnt;
    logic [4:0]  h_rd;
    set_idle();
    set_op(2'b00, 3'b000, 5'd9, 32'h0000_1111, 32'h0, 32'h0);
    cycle();
    h_res = m_res; h_cnt = m_cnt; h_rd = m_rd;
    set_op(2'b00, 3'b000, 5'd3, 32'h0000_00A5, 32'h0, 32'h0);
    StallW = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      vectors++; if (ResultW !== h_res || RdW !== h_rd) begin errors++; $display("FAIL stall_hold_%0d got %h/%0d want %h/%0d", i, ResultW, RdW, h_res, h_rd); end
      vectors++; if (InstrRetW !== h_cnt) begin errors++; $display("FAIL stall_cnt_%0d got %0d want %0d", i, InstrRetW, h_cnt); end
    end
    StallW = 0;
    cycle();
    vectors++; if (ResultW !== 32'hA5 || RdW !== 5'd3) begin errors++; $display("FAIL stall_release got %h/%0d want a5/3", ResultW, RdW); end
    vectors++; if (InstrRetW !== h_cnt + 1) begin errors++; $display("FAIL stall_release_cnt got %0d want %0d", InstrRetW, h_cnt + 1); end
  endtask

  task automatic test_flush();
    logic [31:0] h_cnt;
    h_cnt = m_cnt;
    set_idle();
    set_op(2'b00, 3'b000, 5'd4, 32'h55, 32'h0, 32'h0);
    FlushW = 1; StallW = 1;
    cycle();
    vectors++; if (ValidW !== 1'b0 || RegWriteW !== 1'b0) begin errors++; $display("FAIL flush_bubble got v%0b w%0b want v0 w0", ValidW, RegWriteW); end
    vectors++; if (InstrRetW !== h_cnt) begin errors++; $display("FAIL flush_cnt got %0d want %0d", InstrRetW, h_cnt); end
    vectors++; if (ResultW !== 32'h0 || RdW !== 5'd0) begin errors++; $display("FAIL flush_data got %h/%0d want 0/0", ResultW, RdW); end
  endtask

  task automatic test_pc4();
    set_idle();
    set_op(2'b10, 3'b000, 5'd1, 32'h0, 32'h0, 32'h104);
    cycle();
    vectors++; if (ResultW !== 32'h104 || RegWriteW !== 1'b1) begin errors++; $display("FAIL pc4_rd1 got %h w%0b want 104 w1", ResultW, RegWriteW); end
    RdM = 5'd0;
    cycle();
    vectors++; if (RegWriteW !== 1'b0) begin errors++; $display("FAIL pc4_rd0 got w%0b want w0", RegWriteW); end
    ResultSrcM = 2'b11; RdM = 5'd2;
    cycle();
    vectors++; if (ResultW !== 32'h0) begin errors++; $display("FAIL res_zero got %h want 0", ResultW); end
  endtask

  task automatic test_misalign();
    logic [31:0] h_cnt;
    set_idle();
    set_op(2'b01, 3'b010, 5'd6, 32'd6, 32'hCAFE_BABE, 32'h0);
    h_cnt = m_cnt;
    cycle();
`ifdef MISALIGN_TRAP_EN
    vectors++; if (MisalignW !== 1'b1 || RegWriteW !== 1'b0) begin errors++; $display("FAIL misalign_lw got m%0b w%0b want m1 w0", MisalignW, RegWriteW); end
    vectors++; if (InstrRetW !== h_cnt) begin errors++; $display("FAIL misalign_cnt got %0d want %0d", InstrRetW, h_cnt); end
`else
    vectors++; if (MisalignW !== 1'b0 || RegWriteW !== 1'b1) begin errors++; $display("FAIL misalign_lw got m%0b w%0b want m0 w1", MisalignW, RegWriteW); end
    vectors++; if (InstrRetW !== h_cnt + 1) begin errors++; $display("FAIL misalign_cnt got %0d want %0d", InstrRetW, h_cnt + 1); end
`endif
    vectors++; if (ResultW !== 32'hCAFE_BABE) begin errors++; $display("FAIL misalign_data got %h want cafebabe", ResultW); end
  endtask

  task automatic test_reset_mid_stall();
    set_idle();
    set_op(2'b00, 3'b000, 5'd8, 32'h77, 32'h0, 32'h0);
    cycle();
    rst = 1; StallW = 1; FlushW = 1;
    cycle();
    vectors++; if (ValidW !== 1'b0 || InstrRetW !== 32'h0 || ResultW !== 32'h0) begin
      errors++; $display("FAIL reset_mid_stall got v%0b c%0d r%h want all 0", ValidW, InstrRetW, ResultW);
    end
    set_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 39) == 0);
      FlushW     = ($urandom_range(0, 9) == 0);
      StallW     = ($urandom_range(0, 4) == 0);
      ValidM     = ($urandom_range(0, 3) != 0);
      RegWriteM  = $urandom_range(0, 1);
      ResultSrcM = 2'($urandom_range(0, 3));
      Funct3M    = 3'($urandom_range(0, 7));
      RdM        = 5'($urandom_range(0, 31));
      ALUResultM = $urandom;
      ReadDataM  = $urandom;
      PCPlus4M   = $urandom;
      cycle();
      vectors++;
      if (RegWriteW !== m_rw || RdW !== m_rd || ResultW !== m_res || ValidW !== m_valid ||
          InstrRetW !== m_cnt || MisalignW !== m_mis) begin
        errors++;
        $display("FAIL random_%0d got w%0b rd%0d r%h v%0b c%0d m%0b want w%0b rd%0d r%h v%0b c%0d m%0b", i,
                 RegWriteW, RdW, ResultW, ValidW, InstrRetW, MisalignW, m_rw, m_rd, m_res, m_valid, m_cnt, m_mis);
      end
    end
  endtask

  initial begin
    set_idle();
    m_rw = 0; m_valid = 0; m_mis = 0; m_rd = 0; m_res = 0; m_cnt = 0;
    @(negedge clk);
    test_reset();
    test_load_extend();
    test_stall();
    test_flush();
    test_pc4();
    test_misalign();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
